// File: rtl/mw_pkg.sv
// Shared types, 7-segment codes and the BCD countdown helper for the
// microwave front-panel controller.
package mw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  // Displayed cook time, most significant digit first.
  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } mm_ss_t;

  // Segment patterns {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One-second countdown with BCD borrow. Seconds-tens wraps to 5 so the
  // display stays in MM:SS form; entered values such as 00:90 still count
  // down digit by digit. Never called on 00:00.
  function automatic mm_ss_t time_dec(input mm_ss_t t);
    mm_ss_t r;
    r = t;
    if (t.sec_ones != 4'd0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else begin
      r.sec_ones = 4'd9;
      if (t.sec_tens != 4'd0) begin
        r.sec_tens = t.sec_tens - 4'd1;
      end else begin
        r.sec_tens = 4'd5;
        if (t.min_ones != 4'd0) begin
          r.min_ones = t.min_ones - 4'd1;
        end else begin
          r.min_ones = 4'd9;
          r.min_tens = t.min_tens - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mw_controller_seg7_decoder.sv
// BCD digit to 7-segment pattern; codes above 9 blank the digit.
module seg7_decoder
  import mw_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segs
);

  // Pure lookup of the digit pattern.
  always_comb begin
    // NOTE: every path assigns segs (via the default arm), so no latch is inferred.
    unique case (bcd)
      4'd0:    segs = SEG_0;
      4'd1:    segs = SEG_1;
      4'd2:    segs = SEG_2;
      4'd3:    segs = SEG_3;
      4'd4:    segs = SEG_4;
      4'd5:    segs = SEG_5;
      4'd6:    segs = SEG_6;
      4'd7:    segs = SEG_7;
      4'd8:    segs = SEG_8;
      4'd9:    segs = SEG_9;
      default: segs = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mw_controller.sv
// Microwave front-panel controller: keypad MM:SS entry, start/stop/clear
// handling, one-second countdown while cooking, and four digit displays.
module mw_controller
  import mw_pkg::*;
#(
  parameter int TICK_DIV = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keypad,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  output logic       mag_on,
  output logic [6:0] sec_ones_segs,
  output logic [6:0] sec_tens_segs,
  output logic [6:0] min_ones_segs,
  output logic [6:0] min_tens_segs
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  mm_ss_t        time_q, time_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    keypad_q;
  logic          startn_q;
  logic          key_ok;
  logic          start_ev;
  bcd_t          key_digit;

  // Edge detection: a new one-hot key value, and a falling edge of startn.
  assign key_ok   = $onehot(keypad) && (keypad != keypad_q);
  assign start_ev = startn_q && !startn;

  // Translate the one-hot key into its digit value.
  always_comb begin
    key_digit = '0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) key_digit = bcd_t'(i);
    end
  end

  // Next state, time and tick counter, in priority order:
  // clear, stop/door-open, tick, start, key.
  always_comb begin
    // NOTE: defaults first so unassigned paths hold their value instead of
    // inferring latches.
    state_d = state_q;
    time_d  = time_q;
    cnt_d   = cnt_q;
    if (!clearn) begin
      state_d = IDLE;
      time_d  = '0;
      cnt_d   = '0;
    end else if (state_q == COOK) begin
      if (!stopn || !door_closed) begin
        state_d = PAUSE;
      end else if (cnt_q == TICK_LAST) begin
        cnt_d  = '0;
        time_d = time_dec(time_q);
        if (time_d == '0) state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // IDLE and PAUSE behave alike: entry allowed, start may resume.
      if (start_ev && door_closed && (time_q != '0)) begin
        state_d = COOK;
        cnt_d   = '0;
      end else if (key_ok) begin
        time_d = '{min_tens: time_q.min_ones,
                   min_ones: time_q.sec_tens,
                   sec_tens: time_q.sec_ones,
                   sec_ones: key_digit};
      end
    end
  end

  // State, time, divider, input history and registered magnetron enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      time_q   <= '0;
      cnt_q    <= '0;
      keypad_q <= '0;
      startn_q <= 1'b1;
      mag_on   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      time_q   <= time_d;
      cnt_q    <= cnt_d;
      keypad_q <= keypad;
      startn_q <= startn;
      mag_on   <= (state_d == COOK);
    end
  end

  seg7_decoder u_sec_ones (.bcd(time_q.sec_ones), .segs(sec_ones_segs));
  seg7_decoder u_sec_tens (.bcd(time_q.sec_tens), .segs(sec_tens_segs));
  seg7_decoder u_min_ones (.bcd(time_q.min_ones), .segs(min_ones_segs));
  seg7_decoder u_min_tens (.bcd(time_q.min_tens), .segs(min_tens_segs));

endmodule

// File: tb/tb_mw_controller.sv
// Self-checking bench for mw_controller: directed scenarios followed by
// random stimulus, compared every cycle against a behavioural model that
// holds the time as a four-digit decimal number.
module tb_mw_controller;

  localparam int TICK = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] keypad;
  logic       startn, stopn, clearn, door_closed;
  logic       mag_on;
  logic [6:0] sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  int         m_num;
  bit         m_cook;
  int         m_cnt;
  logic [9:0] m_prev_kp;
  bit         m_prev_st;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  mw_controller #(.TICK_DIV(TICK)) dut (
    .clk           (clk),
    .rst           (rst),
    .keypad        (keypad),
    .startn        (startn),
    .stopn         (stopn),
    .clearn        (clearn),
    .door_closed   (door_closed),
    .mag_on        (mag_on),
    .sec_ones_segs (sec_ones_segs),
    .sec_tens_segs (sec_tens_segs),
    .min_ones_segs (min_ones_segs),
    .min_tens_segs (min_tens_segs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One countdown second on a decimal MMSS number.
  function automatic int dec_time(input int n);
    if (n % 100 == 0) return n - 100 + 59;
    return n - 1;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit key_ok, start_ev;
    key_ok   = ($countones(keypad) == 1) && (keypad != m_prev_kp);
    start_ev = m_prev_st && !startn;
    if (!clearn) begin
      m_cook = 0; m_num = 0; m_cnt = 0;
    end else if (m_cook && (!stopn || !door_closed)) begin
      m_cook = 0;
    end else if (m_cook) begin
      m_cnt++;
      if (m_cnt == TICK) begin
        m_cnt = 0;
        m_num = dec_time(m_num);
        if (m_num == 0) m_cook = 0;
      end
    end else if (start_ev && door_closed && m_num != 0) begin
      m_cook = 1; m_cnt = 0;
    end else if (key_ok) begin
      for (int d = 0; d < 10; d++)
        if (keypad[d]) m_num = (m_num * 10 + d) % 10000;
    end
    m_prev_kp = keypad;
    m_prev_st = startn;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".mag_on"},   {6'b0, mag_on}, {6'b0, m_cook});
    check({tag, ".min_tens"}, min_tens_segs,  seg_tab[m_num / 1000]);
    check({tag, ".min_ones"}, min_ones_segs,  seg_tab[(m_num / 100) % 10]);
    check({tag, ".sec_tens"}, sec_tens_segs,  seg_tab[(m_num / 10) % 10]);
    check({tag, ".sec_ones"}, sec_ones_segs,  seg_tab[m_num % 10]);
  endtask

  // Inputs are driven at the falling edge; one call covers one rising edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic press(input int d);
    keypad = 10'(1 << d);
    step("press");
    keypad = '0;
    step("release");
  endtask

  task automatic show(input string tag, input logic [6:0] mt, input logic [6:0] mo,
                      input logic [6:0] st, input logic [6:0] so);
    check({tag, ".mt"}, min_tens_segs, mt);
    check({tag, ".mo"}, min_ones_segs, mo);
    check({tag, ".st"}, sec_tens_segs, st);
    check({tag, ".so"}, sec_ones_segs, so);
  endtask

  initial begin
    rst = 1'b1; keypad = '0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1;
    m_num = 0; m_cook = 0; m_cnt = 0; m_prev_kp = '0; m_prev_st = 1;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all("post_reset");

    // 1: key 1 then key 2 without release -> 00:12.
    keypad = 10'(1 << 1); step("key1");
    keypad = 10'(1 << 2); step("key2");
    keypad = '0;          step("keyrel");
    show("s1_0012", 7'h3F, 7'h3F, 7'h06, 7'h5B);
    check("s1_mag", {6'b0, mag_on}, 7'h00);

    // 2: start, mag_on immediately, 00:11 after one tick, then run out.
    startn = 1'b0; step("start");
    check("s2_mag_on", {6'b0, mag_on}, 7'h01);
    run("s2_wait", TICK - 1);
    check("s2_before_tick", sec_ones_segs, 7'h5B);
    step("s2_tick");
    check("s2_0011", sec_ones_segs, 7'h06);
    run("s2_count", 11 * TICK);
    check("s2_done_mag", {6'b0, mag_on}, 7'h00);
    show("s2_0000", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    startn = 1'b1; step("s2_rel");

    // 3: 01:00 -> 00:59 after the first tick.
    press(1); press(0); press(0);
    show("s3_0100", 7'h3F, 7'h06, 7'h3F, 7'h3F);
    startn = 1'b0; step("s3_start");
    startn = 1'b1; run("s3_wait", TICK);
    show("s3_0059", 7'h3F, 7'h3F, 7'h6D, 7'h6F);

    // 4: stop at 00:08 with startn held low; no resume until a new edge.
    clearn = 1'b0; step("s4_clear");
    clearn = 1'b1; press(8);
    startn = 1'b0; run("s4_cook", 3);
    stopn = 1'b0;  step("s4_stop");
    stopn = 1'b1;  run("s4_held", 2 * TICK);
    check("s4_paused", {6'b0, mag_on}, 7'h00);
    check("s4_0008", sec_ones_segs, 7'h7F);
    startn = 1'b1; step("s4_rel");
    startn = 1'b0; step("s4_resume");
    check("s4_resumed", {6'b0, mag_on}, 7'h01);
    startn = 1'b1;

    // 5: door open pauses; start with door open or at 00:00 ignored.
    run("s5_cook", 4);
    door_closed = 1'b0; step("s5_door");
    run("s5_held", 2 * TICK);
    startn = 1'b0; step("s5_start_open");
    check("s5_no_start", {6'b0, mag_on}, 7'h00);
    startn = 1'b1; door_closed = 1'b1;
    clearn = 1'b0; step("s5_clear");
    clearn = 1'b1; step("s5_idle");
    startn = 1'b0; step("s5_start_zero");
    check("s5_zero_start", {6'b0, mag_on}, 7'h00);
    startn = 1'b1; step("s5_rel");

    // 6: clear while cooking; two-key value ignored.
    press(5);
    startn = 1'b0; step("s6_start");
    startn = 1'b1; run("s6_cook", 3);
    clearn = 1'b0; step("s6_clear");
    check("s6_mag", {6'b0, mag_on}, 7'h00);
    clearn = 1'b1;
    keypad = 10'b0000000110; step("s6_multi");
    keypad = '0;             step("s6_rel");
    show("s6_0000", 7'h3F, 7'h3F, 7'h3F, 7'h3F);

    // Out-of-range seconds: 00:90 counts down digit-wise.
    press(9); press(0);
    startn = 1'b0; step("s7_start");
    startn = 1'b1; run("s7_wait", TICK);
    show("s7_0089", 7'h3F, 7'h3F, 7'h7F, 7'h6F);
    clearn = 1'b0; step("s7_clear");
    clearn = 1'b1;

    // Random phase.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)       keypad = '0;
      else if (r < 8)  keypad = 10'(1 << $urandom_range(0, 9));
      else if (r == 8) keypad = 10'($urandom);
      startn = ($urandom_range(0, 7) != 0);
      stopn  = ($urandom_range(0, 39) != 0);
      clearn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 59) == 0) door_closed = ~door_closed;
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
